// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader: FSM state codes and parameter legality checks.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  // The FIFO must hold every read that can be in flight plus one beat being drained.
  function automatic bit fifo_depth_legal(input int depth, input int lat);
    return (depth >= lat + 1) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, only the pointers and count.
module stream_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A push into a full FIFO without a simultaneous pop means the credit logic is broken.
  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/ram_stream_reader.sv
// Turns (address, length) commands into one RAM read per cycle and a valid/ready stream with last.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_BITS  = 36,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [ADDR_BITS-1:0] cmd_len,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_en,
  input  logic [DATA_BITS-1:0] ram_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_stream_reader: RD_LAT must be 1 or 2");
  end
  if (!fifo_depth_legal(FIFO_DEPTH, RD_LAT)) begin : g_bad_depth
    $error("ram_stream_reader: FIFO_DEPTH must be a power of 2 and >= RD_LAT+1");
  end

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [ADDR_BITS-1:0] remaining;
  logic                 accept;
  logic                 issue;
  logic                 tag;
  logic                 vld_p1;
  logic                 vld_p2;
  logic                 tag_p1;
  logic                 tag_p2;
  logic                 capture;
  logic                 cap_tag;
  logic [CW-1:0]        in_flight;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          credit_used;
  logic                 fifo_empty;
  logic [DATA_BITS:0]   fifo_dout;
  logic                 pop;
  logic                 last_pop;

  // Credits use only registered counts, so m_ready never reaches ram_addr combinationally.
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign accept      = (state == IDLE) && cmd_valid;
  assign tag         = (remaining == '0);
  assign pop         = !fifo_empty && m_ready;
  assign last_pop    = pop && fifo_dout[DATA_BITS];

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_used < CREDIT_MAX) begin
          issue = 1'b1;
          if (tag) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      in_flight <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      in_flight <= in_flight + CW'(issue) - CW'(capture);
    end
  end

  // Stage p1/p2: issue strobe and last-tag follow the RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      tag_p1 <= 1'b0;
      tag_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      vld_p2 <= vld_p1;
      tag_p1 <= issue && tag;
      tag_p2 <= tag_p1;
    end
  end

  assign capture = (RD_LAT == 1) ? vld_p1 : vld_p2;
  assign cap_tag = (RD_LAT == 1) ? tag_p1 : tag_p2;
  assign ram_en  = (RD_LAT == 1) ? issue  : vld_p1;
  assign ram_addr = cur_addr;

  stream_sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   ({cap_tag, ram_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Data is gated by valid so the stream reads as zero whenever nothing is buffered.
  assign m_valid   = !fifo_empty;
  assign m_data    = m_valid ? fifo_dout[DATA_BITS-1:0] : '0;
  assign m_last    = m_valid && fifo_dout[DATA_BITS];
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

endmodule
